// File: rtl/controle_chamadas_pkg.sv
// Shared constants for the elevator call scheduler: state encoding, floor limits,
// direction values and a one-hot floor helper.
package controle_chamadas_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'b00,
    SUBINDO  = 2'b01,
    DESCENDO = 2'b10,
    PORTA    = 2'b11
  } estado_t;

  localparam logic [1:0] ANDAR_MIN = 2'd0;
  localparam logic [1:0] ANDAR_MAX = 2'd3;

  localparam logic SOBE  = 1'b1;
  localparam logic DESCE = 1'b0;

  function automatic logic [3:0] um_quente(input logic [1:0] a);
    return 4'b0001 << a;
  endfunction

endpackage

// File: rtl/contador_tempo.sv
// Loadable down-counter with terminal-count flag; load wins over decrement,
// and the count holds at zero.
module contador_tempo #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         carga,
  input  logic         decr,
  input  logic [W-1:0] valor,
  output logic         zero
);

  logic [W-1:0] cont;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                    cont <= '0;
    else if (carga)                cont <= valor;
    else if (decr && cont != '0)   cont <= cont - 1'b1;
  end

  assign zero = (cont == '0);

endmodule

// File: rtl/controle_chamadas.sv
// SCAN call scheduler for a 4-floor elevator: latches calls, drives direction and
// step pulses into the floor stage, and times the door at served floors.
module controle_chamadas
  import controle_chamadas_pkg::*;
#(
  parameter int TEMPO_ANDAR = 4,
  parameter int TEMPO_PORTA = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] chamada,
  input  logic [1:0] andar,
  output logic       sentido,
  output logic       passo,
  output logic       porta_aberta,
  output logic [3:0] pendentes
);

  localparam int WA = $clog2(TEMPO_ANDAR + 1);
  localparam int WP = $clog2(TEMPO_PORTA + 1);

  estado_t    estado, prox_estado;
  logic       acima, abaixo, aqui, chama_aqui, frente, atras, limite;
  logic       prox_sentido, prox_passo, prox_porta, abre;
  logic       carga_a, decr_a, zero_a, carga_p, decr_p, zero_p;
  logic [3:0] mask_andar, prox_pend;

  always_comb begin
    acima  = 1'b0;
    abaixo = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (pendentes[i] && (i > int'(andar))) acima  = 1'b1;
      if (pendentes[i] && (i < int'(andar))) abaixo = 1'b1;
    end
  end

  assign aqui       = pendentes[andar];
  assign chama_aqui = chamada[andar];
  assign frente     = sentido ? acima : abaixo;
  assign atras      = sentido ? abaixo : acima;
  assign limite     = sentido ? (andar == ANDAR_MAX) : (andar == ANDAR_MIN);
  assign mask_andar = um_quente(andar);

  always_comb begin
    prox_estado  = estado;
    prox_sentido = sentido;
    prox_passo   = 1'b0;
    prox_porta   = porta_aberta;
    abre         = 1'b0;
    carga_a      = 1'b0;
    decr_a       = 1'b0;
    carga_p      = 1'b0;
    decr_p       = 1'b0;
    case (estado)
      OCIOSO: begin
        if (aqui || chama_aqui) begin
          prox_estado = PORTA;
          abre        = 1'b1;
        end else if (acima) begin
          prox_estado  = SUBINDO;
          prox_sentido = SOBE;
          carga_a      = 1'b1;
        end else if (abaixo) begin
          prox_estado  = DESCENDO;
          prox_sentido = DESCE;
          carga_a      = 1'b1;
        end
      end
      SUBINDO, DESCENDO: begin
        // andar is stale while passo is high; only keep counting then
        if (passo) decr_a = 1'b1;
        else if (zero_a && limite) prox_estado = OCIOSO;
        else if (aqui) begin
          prox_estado = PORTA;
          abre        = 1'b1;
        end else if (frente) begin
          if (zero_a) begin
            prox_passo = 1'b1;
            carga_a    = 1'b1;
          end else decr_a = 1'b1;
        end else if (atras) begin
          prox_sentido = ~sentido;
          prox_estado  = sentido ? DESCENDO : SUBINDO;
          carga_a      = 1'b1;
        end else prox_estado = OCIOSO;
      end
      PORTA: begin
        if (chama_aqui) carga_p = 1'b1;
        else if (zero_p) begin
          prox_porta = 1'b0;
          if (frente) begin
            prox_estado = sentido ? SUBINDO : DESCENDO;
            carga_a     = 1'b1;
          end else if (atras) begin
            prox_sentido = ~sentido;
            prox_estado  = sentido ? DESCENDO : SUBINDO;
            carga_a      = 1'b1;
          end else prox_estado = OCIOSO;
        end else decr_p = 1'b1;
      end
      default: prox_estado = OCIOSO;
    endcase
    if (abre) begin
      prox_porta = 1'b1;
      carga_p    = 1'b1;
    end
  end

  // a press at the open (or opening) door's floor never latches; clear beats set
  always_comb begin
    prox_pend = pendentes | (chamada & ~((porta_aberta || abre) ? mask_andar : 4'b0000));
    if (abre) prox_pend = prox_pend & ~mask_andar;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado       <= OCIOSO;
      pendentes    <= 4'b0000;
      sentido      <= DESCE;
      passo        <= 1'b0;
      porta_aberta <= 1'b0;
    end else begin
      estado       <= prox_estado;
      pendentes    <= prox_pend;
      sentido      <= prox_sentido;
      passo        <= prox_passo;
      porta_aberta <= prox_porta;
    end
  end

  contador_tempo #(.W(WA)) u_tempo_andar (
    .clock (clock),
    .reset (reset),
    .carga (carga_a),
    .decr  (decr_a),
    .valor (WA'(TEMPO_ANDAR - 1)),
    .zero  (zero_a)
  );

  contador_tempo #(.W(WP)) u_tempo_porta (
    .clock (clock),
    .reset (reset),
    .carga (carga_p),
    .decr  (decr_p),
    .valor (WP'(TEMPO_PORTA - 1)),
    .zero  (zero_p)
  );

endmodule

// File: tb/tb_controle_chamadas.sv
// Directed and random checks of the call scheduler against a floor-stage model
// and service/timing rules derived from the elevator behaviour.
`timescale 1ns/1ps
module tb_controle_chamadas;

  localparam int T = 4;
  localparam int P = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] chamada = 4'b0000;
  logic [1:0] andar = 2'd0;
  logic       sentido, passo, porta_aberta;
  logic [3:0] pendentes;

  logic       ovr = 1'b0;
  logic [1:0] ovr_val = 2'd0;

  int n_chk = 0;
  int n_fail = 0;

  int cyc = 0;
  int viol = 0;
  int run = 0;
  int passo_q[$];
  int porta_run_q[$];
  int servido_q[$];
  int ult_porta[4] = '{default: -1};
  logic sent_prev = 1'b0;
  logic porta_prev = 1'b0;

  always #5 clock = ~clock;

  controle_chamadas #(.TEMPO_ANDAR(T), .TEMPO_PORTA(P)) dut (
    .clock        (clock),
    .reset        (reset),
    .chamada      (chamada),
    .andar        (andar),
    .sentido      (sentido),
    .passo        (passo),
    .porta_aberta (porta_aberta),
    .pendentes    (pendentes)
  );

  // floor stage: moves one floor on every edge that sees passo
  always @(posedge clock) begin
    if (ovr) andar <= ovr_val;
    else if (passo) andar <= sentido ? andar + 2'd1 : andar - 2'd1;
  end

  // event recorder and safety rules, sampled 1ns after each rising edge
  always @(posedge clock) begin
    #1;
    cyc++;
    if (reset) begin
      if (passo) passo_q.push_back(cyc);
      if (passo && porta_aberta) viol++;
      if (passo && sentido && andar == 2'd3) viol++;
      if (passo && !sentido && andar == 2'd0) viol++;
      if (passo && sentido !== sent_prev) viol++;
      if (porta_aberta) begin
        run++;
        ult_porta[andar] = cyc;
        if (!porta_prev) servido_q.push_back(int'(andar));
      end else if (porta_prev) begin
        porta_run_q.push_back(run);
        run = 0;
      end
      sent_prev  = sentido;
      porta_prev = porta_aberta;
    end else begin
      run        = 0;
      sent_prev  = 1'b0;
      porta_prev = 1'b0;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic ciclo(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chama(input logic [3:0] c);
    chamada = c;
    @(negedge clock);
    chamada = 4'b0000;
  endtask

  task automatic poe_andar(input logic [1:0] a);
    ovr = 1'b1;
    ovr_val = a;
    @(negedge clock);
    ovr = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    int c0, np0, nr0, ns0;
    int press[4];
    logic [3:0] c;
    int f;
    bit drenado;

    #2 reset = 1'b0;
    #1;
    chk("reset_pendentes", int'(pendentes), 0);
    chk("reset_sentido", int'(sentido), 0);
    chk("reset_passo", int'(passo), 0);
    chk("reset_porta", int'(porta_aberta), 0);
    ciclo(2);
    reset = 1'b1;
    ciclo(10);
    chk("idle_no_passo", passo_q.size(), 0);
    chk("idle_porta", int'(porta_aberta), 0);
    chk("idle_pendentes", int'(pendentes), 0);

    // single call from floor 0 to floor 3
    np0 = passo_q.size(); nr0 = porta_run_q.size(); ns0 = servido_q.size(); c0 = cyc;
    chama(4'b1000);
    chk("up_latch", int'(pendentes), 4'b1000);
    ciclo(1);
    chk("up_sentido", int'(sentido), 1);
    ciclo(30);
    chk("up_passo_count", passo_q.size() - np0, 3);
    chk("up_first_passo", passo_q[np0] - c0, 2 + T);
    chk("up_spacing", passo_q[np0+2] - passo_q[np0], 2 * T);
    chk("up_served", servido_q[ns0], 3);
    chk("up_door_len", porta_run_q[nr0], P);
    chk("up_pend_clear", int'(pendentes), 0);
    chk("up_andar", int'(andar), 3);

    // call at the current floor, then re-pressed while the door is open
    poe_andar(2'd2);
    np0 = passo_q.size(); nr0 = porta_run_q.size(); ns0 = servido_q.size();
    chama(4'b0100);
    chk("here_door_next_edge", int'(porta_aberta), 1);
    chk("here_pend_not_set", int'(pendentes), 0);
    ciclo(2);
    chama(4'b0100);
    chk("here_repress_pend", int'(pendentes), 0);
    ciclo(15);
    chk("here_door_len", porta_run_q[nr0], 3 + P);
    chk("here_served", servido_q[ns0], 2);
    chk("here_no_passo", passo_q.size() - np0, 0);

    // SCAN order: up first to 3, then reverse down to 0
    poe_andar(2'd1);
    np0 = passo_q.size(); nr0 = porta_run_q.size(); ns0 = servido_q.size(); c0 = cyc;
    chama(4'b1001);
    ciclo(1);
    chk("scan_sentido_up", int'(sentido), 1);
    ciclo(50);
    chk("scan_first_served", servido_q[ns0], 3);
    chk("scan_second_served", servido_q[ns0+1], 0);
    chk("scan_door1", porta_run_q[nr0], P);
    chk("scan_door2", porta_run_q[nr0+1], P);
    chk("scan_passo_count", passo_q.size() - np0, 5);
    chk("scan_down_first_passo", passo_q[np0+2] - c0, 4 + 3 * T + P);
    chk("scan_sentido_down", int'(sentido), 0);
    chk("scan_andar", int'(andar), 0);

    // mid-travel pickup at floor 2
    np0 = passo_q.size(); nr0 = porta_run_q.size(); ns0 = servido_q.size();
    chama(4'b1000);
    for (int i = 0; i < 40 && andar != 2'd1; i++) @(negedge clock);
    chk("pick_reach_1", int'(andar), 1);
    chama(4'b0100);
    ciclo(50);
    chk("pick_served_2", servido_q[ns0], 2);
    chk("pick_served_3", servido_q[ns0+1], 3);
    chk("pick_door1", porta_run_q[nr0], P);
    chk("pick_door2", porta_run_q[nr0+1], P);
    chk("pick_passo_count", passo_q.size() - np0, 3);
    chk("pick_pend_clear", int'(pendentes), 0);

    // boundary guard: floor forced to 3 just as the first step is due
    poe_andar(2'd0);
    np0 = passo_q.size();
    chama(4'b1000);
    ciclo(3);
    ovr = 1'b1; ovr_val = 2'd3;
    ciclo(1);
    ovr = 1'b0;
    ciclo(1);
    chk("guard_no_passo", int'(passo), 0);
    chk("guard_no_door", int'(porta_aberta), 0);
    ciclo(1);
    chk("guard_idle_then_door", int'(porta_aberta), 1);
    chk("guard_passo_count", passo_q.size() - np0, 0);
    ciclo(12);

    // reset mid-travel with a step about to be issued
    poe_andar(2'd0);
    chama(4'b1000);
    ciclo(4);
    reset = 1'b0;
    #1;
    chk("rst_mid_passo", int'(passo), 0);
    chk("rst_mid_porta", int'(porta_aberta), 0);
    chk("rst_mid_sentido", int'(sentido), 0);
    chk("rst_mid_pendentes", int'(pendentes), 0);
    @(negedge clock);
    reset = 1'b1;
    np0 = passo_q.size();
    ciclo(12);
    chk("rst_rel_no_passo", passo_q.size() - np0, 0);
    chk("rst_rel_porta", int'(porta_aberta), 0);
    chk("rst_rel_pend", int'(pendentes), 0);

    // random calls: every pressed floor must later see its door open
    for (int k = 0; k < 4; k++) press[k] = -1;
    for (int n = 0; n < 400; n++) begin
      c = 4'b0000;
      if ($urandom_range(0, 7) == 0) begin
        f = int'($urandom_range(0, 3));
        c = 4'(1 << f);
        press[f] = cyc + 1;
      end
      chamada = c;
      @(negedge clock);
    end
    chamada = 4'b0000;
    drenado = 1'b0;
    for (int i = 0; i < 300 && !drenado; i++) begin
      @(negedge clock);
      if (pendentes == 4'b0000 && !porta_aberta && !passo) drenado = 1'b1;
    end
    chk("rand_drained", int'(drenado), 1);
    for (int k = 0; k < 4; k++)
      if (press[k] >= 0) chk($sformatf("rand_served_%0d", k), int'(ult_porta[k] >= press[k]), 1);

    chk("safety_rules", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
